// File: rtl/traffic_light_pkg.sv
// Shared types and helpers for the three-phase traffic-light sequencer.
// Phase encoding, per-phase dwell lookup, phase rotation and lamp decode.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'b00,
    YELLOW = 2'b01,
    RED    = 2'b10
  } state_e;

  // Lamp vector ordering used throughout: {red, yellow, green}.
  localparam logic [2:0] LAMPS_GREEN  = 3'b001;
  localparam logic [2:0] LAMPS_YELLOW = 3'b010;
  localparam logic [2:0] LAMPS_RED    = 3'b100;

  function automatic int dwell_cycles(input state_e s, input int g_cycles,
                                      input int y_cycles, input int r_cycles);
    int n;
    n = 1;
    case (s)
      GREEN:   n = g_cycles;
      YELLOW:  n = y_cycles;
      RED:     n = r_cycles;
      default: n = 1;
    endcase
    return n;
  endfunction

  function automatic state_e next_phase(input state_e s);
    state_e n;
    n = GREEN;
    case (s)
      GREEN:   n = YELLOW;
      YELLOW:  n = RED;
      RED:     n = GREEN;
      default: n = GREEN;
    endcase
    return n;
  endfunction

  // Illegal encodings decode to green so the lamps are never dark or multi-hot.
  function automatic logic [2:0] lamp_decode(input state_e s);
    logic [2:0] l;
    l = LAMPS_GREEN;
    case (s)
      GREEN:   l = LAMPS_GREEN;
      YELLOW:  l = LAMPS_YELLOW;
      RED:     l = LAMPS_RED;
      default: l = LAMPS_GREEN;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_controller.sv
// Free-running GREEN -> YELLOW -> RED sequencer with exact per-phase dwell
// counts; lamp outputs come straight from registers.
module traffic_light_controller
  import traffic_light_pkg::*;
#(
  parameter int GREEN_CYCLES  = 250_000_000,
  parameter int YELLOW_CYCLES = 100_000_000,
  parameter int RED_CYCLES    = 250_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic red,
  output logic yellow,
  output logic green
);

  localparam int MAX_CYCLES =
    (GREEN_CYCLES > YELLOW_CYCLES)
      ? ((GREEN_CYCLES > RED_CYCLES) ? GREEN_CYCLES : RED_CYCLES)
      : ((YELLOW_CYCLES > RED_CYCLES) ? YELLOW_CYCLES : RED_CYCLES);
  localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  if (GREEN_CYCLES < 1 || YELLOW_CYCLES < 1 || RED_CYCLES < 1) begin : g_bad_params
    $error("traffic_light_controller: every dwell parameter must be >= 1");
  end

  state_e          state_r;
  state_e          state_next_s;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic [CW-1:0]   last_s;
  logic [2:0]      lamps_r;

  // Terminal count of the phase currently being served.
  always_comb begin
    last_s = CW'(dwell_cycles(state_r, GREEN_CYCLES, YELLOW_CYCLES, RED_CYCLES) - 1);
  end

  // Next-state and dwell-counter update; >= keeps a corrupted count from running away.
  always_comb begin
    state_next_s = GREEN;
    count_next_s = '0;
    case (state_r)
      GREEN, YELLOW, RED: begin
        if (count_r >= last_s) begin
          state_next_s = next_phase(state_r);
          count_next_s = '0;
        end else begin
          state_next_s = state_r;
          count_next_s = count_r + CW'(1'b1);
        end
      end
      default: begin
        state_next_s = GREEN;
        count_next_s = '0;
      end
    endcase
  end

  // State, counter and lamp registers; lamps load the decode of the next state
  // so they always match the state register without a combinational tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= GREEN;
      count_r <= '0;
      lamps_r <= LAMPS_GREEN;
    end else begin
      state_r <= state_next_s;
      count_r <= count_next_s;
      lamps_r <= lamp_decode(state_next_s);
    end
  end

  assign red    = lamps_r[2];
  assign yellow = lamps_r[1];
  assign green  = lamps_r[0];

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: three controllers (10/5/15, 1/1/1, 3/1/2) share clk/rst;
// expected lamps come from elapsed-edges-mod-period arithmetic.
module tb_traffic_light_controller;

  localparam int NI = 3;
  localparam int GP [NI] = '{10, 1, 3};
  localparam int YP [NI] = '{5, 1, 1};
  localparam int RP [NI] = '{15, 1, 2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic red_a, yellow_a, green_a;
  logic red_b, yellow_b, green_b;
  logic red_c, yellow_c, green_c;

  int errors = 0;
  int checks = 0;
  int edge_no = 0;
  int k [NI];
  logic [8:0] exp_q [$];

  always #10 clk = ~clk;

  traffic_light_controller #(.GREEN_CYCLES(10), .YELLOW_CYCLES(5), .RED_CYCLES(15)) u_dut_a (
    .clk(clk), .rst(rst), .red(red_a), .yellow(yellow_a), .green(green_a));
  traffic_light_controller #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .RED_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst), .red(red_b), .yellow(yellow_b), .green(green_b));
  traffic_light_controller #(.GREEN_CYCLES(3), .YELLOW_CYCLES(1), .RED_CYCLES(2)) u_dut_c (
    .clk(clk), .rst(rst), .red(red_c), .yellow(yellow_c), .green(green_c));

  // Lamps after kk edges since the last reset edge: position within the period.
  function automatic logic [2:0] model_lamps(input int i, input int kk);
    int p;
    p = kk % (GP[i] + YP[i] + RP[i]);
    if (p < GP[i]) return 3'b001;
    else if (p < GP[i] + YP[i]) return 3'b010;
    else return 3'b100;
  endfunction

  function automatic logic [2:0] observed(input int i);
    case (i)
      0:       return {red_a, yellow_a, green_a};
      1:       return {red_b, yellow_b, green_b};
      default: return {red_c, yellow_c, green_c};
    endcase
  endfunction

  // Drive rst for the coming edge and queue what every instance must show after it.
  task automatic step(input logic r);
    logic [8:0] e;
    @(negedge clk);
    rst = r;
    for (int i = 0; i < NI; i++) begin
      if (r) k[i] = 0;
      else k[i] = k[i] + 1;
      e[3*i +: 3] = model_lamps(i, k[i]);
    end
    exp_q.push_back(e);
  endtask

  // Monitor: pop one expectation per edge and compare, plus one-hot and count bounds.
  initial begin : monitor
    logic [8:0] e;
    logic [2:0] got;
    logic [2:0] want;
    int bound;
    forever begin
      @(posedge clk);
      #1;
      edge_no++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          got = observed(i);
          want = e[3*i +: 3];
          checks++;
          if (got !== want) begin
            errors++;
            $display("FAIL lamps inst%0d edge%0d: got %b required %b", i, edge_no, got, want);
          end
          checks++;
          if ($countones(got) != 1 || $isunknown(got)) begin
            errors++;
            $display("FAIL onehot inst%0d edge%0d: got %b required exactly one lamp", i, edge_no, got);
          end
        end
        want = e[8:6];
        bound = (want == 3'b001) ? 2 : ((want == 3'b010) ? 0 : 1);
        checks++;
        if (int'(u_dut_c.count_r) > bound) begin
          errors++;
          $display("FAIL count_bound inst2 edge%0d: got %0d required <= %0d",
                   edge_no, u_dut_c.count_r, bound);
        end
        checks++;
        if (u_dut_b.count_r !== 1'b0) begin
          errors++;
          $display("FAIL count_zero inst1 edge%0d: got %b required 0", edge_no, u_dut_b.count_r);
        end
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < NI; i++) k[i] = 0;
    rst = 1'b1;
    step(1'b1);
    step(1'b1);
    // Three full periods of the 10/5/15 instance and a bit more.
    repeat (95) step(1'b0);
    // One-cycle reset at yellow count 2 of the main instance.
    for (int n = 0; n < 40 && (k[0] % 30) != 12; n++) step(1'b0);
    step(1'b1);
    repeat (40) step(1'b0);
    // Long reset hold, then normal timing again.
    repeat (20) step(1'b1);
    repeat (40) step(1'b0);
    // Random sparse resets, occasionally held for a few cycles.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(1, 3)) step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Free-running three-phase traffic-light sequencer. It drives mutually exclusive red, yellow and green lamp outputs in the fixed order GREEN → YELLOW → RED → GREEN. Each phase lasts a parameterised number of clock cycles. It sits at the leaf of the signalling subsystem and has no handshake inputs; its outputs feed lamp drivers directly.

## Interface
Parameters:
- GREEN_CYCLES, default 250_000_000: dwell time of the green phase in clock cycles; must be ≥ 1.
- YELLOW_CYCLES, default 100_000_000: dwell time of the yellow phase in clock cycles; must be ≥ 1.
- RED_CYCLES, default 250_000_000: dwell time of the red phase in clock cycles; must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- red  output  1  red lamp on.
- yellow  output  1  yellow lamp on.
- green  output  1  green lamp on.

## Operation
- Moore FSM with three states: GREEN, YELLOW and RED.
- The dwell counter width is $clog2 of the largest parameter, minimum 1 bit. The counter is unsigned.
- Within a state, the counter runs 0 … N−1, where N is that state's parameter.
  - While count < N−1: count increments and the state holds.
  - When count == N−1: the state advances (GREEN→YELLOW, YELLOW→RED, RED→GREEN) and count returns to 0.
- Outputs are decoded from the state register only, with no combinational path from any input:
  - green = (state == GREEN)
  - yellow = (state == YELLOW)
  - red = (state == RED)
- Exactly one output is high in every cycle after the first reset. The outputs are never all-low and never multi-hot.
- Illegal state encodings recover to GREEN with count 0 on the next edge.
- Reset:
  - On any edge where rst = 1, state becomes GREEN and count becomes 0.
  - Reset values of the outputs: green = 1, yellow = 0, red = 0.
  - rst has priority over every transition, including a reset asserted mid-phase. The machine restarts a full green phase.
- Before the first reset the outputs are undefined. The bench must reset first.

## Timing
- Latency: the outputs change one clock edge after the terminal count is reached. There is no extra pipeline stage.
- Dwell time is exact:
  - after the last edge with rst high, green stays high for exactly GREEN_CYCLES rising edges;
  - then yellow stays high for YELLOW_CYCLES edges;
  - then red stays high for RED_CYCLES edges;
  - then the sequence repeats.
- Full period = GREEN_CYCLES + YELLOW_CYCLES + RED_CYCLES cycles, with no dead cycle between phases.
- Boundary case N = 1: that phase lasts exactly one cycle. The counter stays at 0 and the state advances on every edge.
- Count wrap: the counter never exceeds N−1 and never overflows its width.

## Structure
- Shared package traffic_light_pkg holds:
  - the state typedef, a 2-bit enum: GREEN = 2'b00, YELLOW = 2'b01, RED = 2'b10; 2'b11 is illegal;
  - a function returning the dwell length for a given state.
- A single flat module is sufficient; no sub-module is required.
- Static parameter check: any parameter < 1 triggers an elaboration error.

## Test plan
Use GREEN = 10, YELLOW = 5, RED = 15 and a 20 ns clock (period 30 cycles) unless stated otherwise.
- Reset for 2 cycles, then release → green = 1 for 10 edges, yellow = 1 for 5, red = 1 for 15, green again at edge 30. Check across 3 full periods (90 cycles).
- One-hot check → red + yellow + green == 1 at every sampled edge after reset.
- Assert rst for 1 cycle at yellow count 2 → the next edge gives green = 1, and green lasts a full 10 cycles.
- Hold rst high for 20 cycles → green = 1 and the outputs stay constant throughout. After release, normal timing resumes from the start of green.
- With parameters 1/1/1 → the outputs rotate green → yellow → red every cycle, period 3.
- With parameters 3/1/2 → green lasts 3 cycles, yellow 1, red 2, and the counter never exceeds the active parameter − 1.
